// File: rtl/l2_ctrl_pkg.sv
// Shared constants and state encoding for the layer-2 MAC sequencer.
package l2_ctrl_pkg;

  localparam int N_IN             = 32;
  localparam int N_OUT            = 10;
  localparam int ACC_W            = 20;
  localparam int AW               = $clog2(N_IN);
  localparam int L2_LATENCY       = 35;
  localparam int L2_ARGMAX_CYCLES = 9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_STREAM,
    S_DRAIN,
    S_SETTLE,
    S_ARGMAX,
    S_DONE
  } state_t;

endpackage

// File: rtl/l2_seq_ctrl_argmax.sv
// Sequential signed max-index scanner: one lane per cycle, lanes 1..N_OUT-1
// against a running best seeded with lane 0; strict '>' keeps the lower index on ties.
module argmax_seq
  import l2_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic                   cancel,
  input  logic [N_OUT*ACC_W-1:0] vec,
  output logic                   last,
  output logic [3:0]             idx
);

  logic                    running;
  logic [3:0]              cnt;
  logic [3:0]              best;
  logic signed [ACC_W-1:0] cand;
  logic signed [ACC_W-1:0] champ;
  logic                    better;

  always_comb begin
    cand   = vec[cnt*ACC_W +: ACC_W];
    champ  = vec[best*ACC_W +: ACC_W];
    better = cand > champ;
    last   = running && (cnt == 4'(L2_ARGMAX_CYCLES));
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running <= 1'b0;
      cnt     <= '0;
      best    <= '0;
      idx     <= '0;
    end else if (cancel) begin
      running <= 1'b0;
    end else if (load) begin
      running <= 1'b1;
      cnt     <= 4'd1;
      best    <= '0;
    end else if (running) begin
      if (better) best <= cnt;
      cnt <= cnt + 1'b1;
      if (last) begin
        running <= 1'b0;
        idx     <= better ? cnt : best;
      end
    end
  end

endmodule

// File: rtl/l2_seq_ctrl.sv
// Layer-2 MAC array sequencer: streams 32 activations/weight rows, drains the
// product stage, captures logits. Optional argmax under L2_SEQ_ARGMAX_EN.
module l2_seq_ctrl
  import l2_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  output logic                   rd_en,
  output logic [AW-1:0]          rd_addr,
  output logic                   act_zero,
  output logic                   mac_en,
  output logic                   mac_init_bias,
  output logic                   mac_clr,
  input  logic [N_OUT*ACC_W-1:0] acc_in,
  output logic [N_OUT*ACC_W-1:0] logits,
  output logic [3:0]             class_idx,
  output logic                   busy,
  output logic                   done
);

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] k;
  logic          scan_last;
  logic          do_abort;

  assign do_abort = abort && (state != S_IDLE);
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every signal driven here gets a default first, so no branch can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt     = state;
    mac_en        = 1'b0;
    mac_init_bias = 1'b0;
    act_zero      = 1'b0;
    case (state)
      S_IDLE:   if (start) state_nxt = S_FETCH;
      S_FETCH:  state_nxt = S_STREAM;
      S_STREAM: begin
        mac_en        = 1'b1;
        mac_init_bias = (k == '0);
        if (k == AW'(N_IN - 1)) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        mac_en    = 1'b1;
        act_zero  = 1'b1;
        state_nxt = S_SETTLE;
      end
`ifdef L2_SEQ_ARGMAX_EN
      S_SETTLE: state_nxt = S_ARGMAX;
`else
      S_SETTLE: state_nxt = S_DONE;
`endif
      S_ARGMAX: if (scan_last) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
    if (do_abort) state_nxt = S_IDLE;
  end

  // Read port runs one cycle ahead of the stream: address k+1 is issued while
  // data for k is consumed, and the port idles once 31 has been issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en   <= 1'b0;
      rd_addr <= '0;
      k       <= '0;
      mac_clr <= 1'b0;
      logits  <= '0;
    end else begin
      mac_clr <= 1'b0;
      if (do_abort) begin
        mac_clr <= 1'b1;
        rd_en   <= 1'b0;
      end else begin
        case (state)
          S_IDLE: if (start) begin
            rd_en   <= 1'b1;
            rd_addr <= '0;
          end
          S_FETCH: begin
            rd_addr <= AW'(1);
            k       <= '0;
          end
          S_STREAM: begin
            k <= k + 1'b1;
            if (rd_addr == AW'(N_IN - 1)) rd_en   <= 1'b0;
            else                          rd_addr <= rd_addr + 1'b1;
          end
          S_SETTLE: logits <= acc_in;
          default: ;
        endcase
      end
    end
  end

`ifdef L2_SEQ_ARGMAX_EN
  argmax_seq u_argmax (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (state == S_SETTLE && !abort),
    .cancel (abort),
    .vec    (logits),
    .last   (scan_last),
    .idx    (class_idx)
  );
`else
  assign scan_last = 1'b0;
  assign class_idx = '0;
`endif

endmodule

// File: tb/tb_l2_seq_ctrl.sv
// Directed bench for l2_seq_ctrl with a behavioural buffer/ROM and MAC array
// (one-stage product pipeline, init priority, synchronous clear).
module tb_l2_seq_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         abort;
  logic         rd_en;
  logic [4:0]   rd_addr;
  logic         act_zero;
  logic         mac_en;
  logic         mac_init_bias;
  logic         mac_clr;
  logic [199:0] acc_in;
  logic [199:0] logits;
  logic [3:0]   class_idx;
  logic         busy;
  logic         done;

  always #5 clk = ~clk;

  l2_seq_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .abort         (abort),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .act_zero      (act_zero),
    .mac_en        (mac_en),
    .mac_init_bias (mac_init_bias),
    .mac_clr       (mac_clr),
    .acc_in        (acc_in),
    .logits        (logits),
    .class_idx     (class_idx),
    .busy          (busy),
    .done          (done)
  );

`ifdef L2_SEQ_ARGMAX_EN
  localparam int LAT = 44;
`else
  localparam int LAT = 35;
`endif

  // Environment: activation buffer, weight ROM, bias registers, MAC array.
  logic signed [7:0] act_mem [32];
  logic [9:0][7:0]   w_mem   [32];
  logic [9:0][7:0]   bias_m;
  logic signed [7:0] act_q;
  logic [9:0][7:0]   w_q;
  int                prod_m  [10];
  int                acc_m   [10];

  always @(posedge clk) begin
    if (rd_en) begin
      act_q <= act_mem[rd_addr];
      w_q   <= w_mem[rd_addr];
    end
    for (int j = 0; j < 10; j++) begin
      if (!rst_n || mac_clr) begin
        prod_m[j] <= 0;
        acc_m[j]  <= 0;
      end else if (mac_en) begin
        prod_m[j] <= act_zero ? 0 : int'(act_q) * int'($signed(w_q[j]));
        acc_m[j]  <= mac_init_bias ? int'($signed(bias_m[j])) : acc_m[j] + prod_m[j];
      end
    end
  end

  always_comb begin
    acc_in = '0;
    for (int j = 0; j < 10; j++) acc_in[j*20 +: 20] = acc_m[j][19:0];
  end

  typedef struct packed {
    logic signed [7:0] act;
    logic [9:0][7:0]   w;
    logic [9:0][7:0]   b;
    logic [9:0][19:0]  exp;
    logic [3:0]        cls;
  } vec_t;

  vec_t tbl [4];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, $signed(got), $signed(want));
    end
  endtask

  function automatic logic [31:0] lane_of(input int j);
    return 32'($signed(logits[j*20 +: 20]));
  endfunction

  task automatic load_row(input int v);
    for (int i = 0; i < 32; i++) begin
      act_mem[i] = tbl[v].act;
      w_mem[i]   = tbl[v].w;
    end
    bias_m = tbl[v].b;
  endtask

  task automatic check_logits(input int v, input string tag);
    for (int j = 0; j < 10; j++)
      check($sformatf("%s_lane%0d_v%0d", tag, j, v), lane_of(j), 32'($signed(tbl[v].exp[j])));
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Full inference; poke=1 raises start again mid-run (must be ignored).
  task automatic run_vec(input int v, input bit poke);
    int done_n, n_addr, en_cnt;
    bit addr_ok, ib_ok, az_ok, busy_ok;
    load_row(v);
    start = 1'b1;
    step();
    start   = 1'b0;
    done_n  = -1;
    n_addr  = 0;
    en_cnt  = 0;
    addr_ok = 1'b1;
    ib_ok   = 1'b1;
    az_ok   = 1'b1;
    busy_ok = 1'b1;
    for (int n = 0; n < 60 && done_n < 0; n++) begin
      if (n > 0) step();
      start = poke && (n == 5);
      if (rd_en) begin
        if (rd_addr != 5'(n_addr)) addr_ok = 1'b0;
        n_addr++;
      end
      if (mac_en) en_cnt++;
      if (mac_init_bias != (n == 1)) ib_ok = 1'b0;
      if (act_zero != (n == 33)) az_ok = 1'b0;
      if (!busy) busy_ok = 1'b0;
      if (done) done_n = n;
    end
    start = 1'b0;
    check($sformatf("latency_v%0d", v), done_n, LAT);
    check($sformatf("rd_addr_seq_v%0d", v), {n_addr[30:0], addr_ok}, {31'd32, 1'b1});
    check($sformatf("mac_en_cycles_v%0d", v), en_cnt, 33);
    check($sformatf("init_bias_only_k0_v%0d", v), 32'(ib_ok), 1);
    check($sformatf("act_zero_only_drain_v%0d", v), 32'(az_ok), 1);
    check($sformatf("busy_during_run_v%0d", v), 32'(busy_ok), 1);
    check_logits(v, "logit");
`ifdef L2_SEQ_ARGMAX_EN
    check($sformatf("class_idx_v%0d", v), 32'(class_idx), 32'(tbl[v].cls));
`else
    check($sformatf("class_idx_v%0d", v), 32'(class_idx), 0);
`endif
    step();
    check($sformatf("idle_after_done_v%0d", v), {30'b0, busy, done}, 0);
  endtask

  initial begin
    bit saw_done;
    // Row 0: all ones, zero bias -> 32 everywhere, tie -> lane 0.
    tbl[0].act = 8'sd1;
    for (int j = 0; j < 10; j++) begin
      tbl[0].w[j] = 8'd1;  tbl[0].b[j] = 8'd0;  tbl[0].exp[j] = 20'd32;
    end
    tbl[0].cls = 4'd0;
    // Row 1: act 3, lane 7 weight 2, bias 5 -> 197 / 101.
    tbl[1].act = 8'sd3;
    for (int j = 0; j < 10; j++) begin
      tbl[1].w[j] = (j == 7) ? 8'd2 : 8'd1;
      tbl[1].b[j] = 8'd5;
      tbl[1].exp[j] = (j == 7) ? 20'd197 : 20'd101;
    end
    tbl[1].cls = 4'd7;
    // Row 2: act -128; lane 0 weight 127, lanes 4/6 weight 1, rest 2.
    tbl[2].act = -8'sd128;
    for (int j = 0; j < 10; j++) begin
      tbl[2].b[j] = 8'd0;
      if (j == 0) begin
        tbl[2].w[j] = 8'd127;  tbl[2].exp[j] = 20'(-520192);
      end else if (j == 4 || j == 6) begin
        tbl[2].w[j] = 8'd1;    tbl[2].exp[j] = 20'(-4096);
      end else begin
        tbl[2].w[j] = 8'd2;    tbl[2].exp[j] = 20'(-8192);
      end
    end
    tbl[2].cls = 4'd4;
    // Row 3: act 1, lane j weight j -> 32*j, max in the last lane.
    tbl[3].act = 8'sd1;
    for (int j = 0; j < 10; j++) begin
      tbl[3].w[j] = 8'(j);  tbl[3].b[j] = 8'd0;  tbl[3].exp[j] = 20'(32 * j);
    end
    tbl[3].cls = 4'd9;

    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    load_row(0);
    repeat (3) @(negedge clk);
    check("reset_ctrl", {20'b0, rd_en, act_zero, mac_en, mac_init_bias, mac_clr, busy, done, rd_addr}, 0);
    check("reset_logits", {31'b0, |logits}, 0);
    check("reset_class", 32'(class_idx), 0);
    rst_n = 1'b1;
    step();

    // Table vectors, each started the cycle after the previous done.
    for (int v = 0; v < 3; v++) run_vec(v, v == 1);

    // Abort at STREAM k=10 (cycle after E11): clr pulse, no done, logits held.
    load_row(3);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (11) step();
    check("abort_at_k10_streaming", {30'b0, mac_en, mac_init_bias}, 32'b10);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_clr_cycle", {25'b0, mac_clr, mac_en, mac_init_bias, act_zero, rd_en, busy, done}, 32'b1000000);
    step();
    check("abort_clr_one_cycle", {31'b0, mac_clr}, 0);
    saw_done = 1'b0;
    for (int n = 0; n < 50; n++) begin
      step();
      if (done || busy) saw_done = 1'b1;
    end
    check("abort_no_done", 32'(saw_done), 0);
    check_logits(2, "abort_hold");
    run_vec(3, 1'b0);

    // Asynchronous reset in the drain cycle (after E33).
    load_row(1);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (33) step();
    check("pre_reset_in_drain", {31'b0, act_zero}, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrun_reset_ctrl", {20'b0, rd_en, act_zero, mac_en, mac_init_bias, mac_clr, busy, done, rd_addr}, 0);
    check("midrun_reset_logits", {31'b0, |logits}, 0);
    check("midrun_reset_class", 32'(class_idx), 0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int n = 0; n < 50; n++) begin
      step();
      if (done || busy) saw_done = 1'b1;
    end
    check("reset_no_done", 32'(saw_done), 0);
    run_vec(1, 1'b0);
    run_vec(0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/l2_seq_ctrl.md
# l2_seq_ctrl

Sequencer for the 10-output layer-2 MAC array. On `start` it streams the 32 hidden activations and their packed weight rows from synchronous-read buffers into the array. It drives the array's `en`/`init_bias`/`clr` controls, absorbs the array's one-stage product pipeline, captures the 10 final accumulators, and optionally reduces them to a class index. It sits between the layer-1 result buffer/weight ROM and the top-level inference FSM.

## Interface
- `N_IN`, 32: hidden activations per inference.
- `N_OUT`, 10: MAC lanes/outputs.
- `ACC_W`, 20: accumulator width per lane.
- `AW`, $clog2(N_IN): buffer address width.
- `clk`  in  1  sole clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  start request, sampled in IDLE only.
- `abort`  in  1  synchronous abort; returns to IDLE.
- `rd_en`  out  1  read enable to activation buffer and weight ROM.
- `rd_addr`  out  AW  shared read address (activation index = weight row).
- `act_zero`  out  1  forces array activation input to 0 (drain cycle).
- `mac_en`, `mac_init_bias`, `mac_clr`  out  1 each  array controls.
- `acc_in`  in  N_OUT*ACC_W  packed array accumulators.
- `logits`  out  N_OUT*ACC_W  captured accumulators.
- `class_idx`  out  4  argmax result (macro-dependent).
- `busy`  out  1  high from accepted start until done.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE → FETCH → STREAM → DRAIN → SETTLE → (ARGMAX) → DONE → IDLE.
- IDLE: `start`=1 accepted; `rd_en`=1, `rd_addr`=0, `busy`=1, go FETCH. `start` while busy is ignored.
- FETCH (1 cycle): `rd_addr`→1; memory data for index 0 valid next cycle.
- STREAM (32 cycles, k=0..31): `mac_en`=1; `mac_init_bias`=1 only at k=0; `rd_addr` increments to 31 then holds; `rd_en` drops after issuing 31.
- DRAIN (1 cycle): `mac_en`=1, `act_zero`=1, flushing product 31 into the accumulators.
- SETTLE (1 cycle): all MAC controls 0; `acc_in` is final; capture into `logits`.
- ARGMAX: sequential scan of lanes 1..9 against the running best (seed lane 0); signed strict `>` comparison, so ties keep the lower index.
- DONE: `done`=1 for one cycle, `busy`=0 next cycle; `logits`/`class_idx` hold until the next capture.
- `abort` in any non-IDLE state: `mac_clr`=1 for one cycle, all other MAC/read controls 0, `done` not asserted, return to IDLE. `abort` has priority over same-cycle state progress.
- `mac_init_bias` and `mac_en` are asserted together at k=0. The array gives init priority in the accumulate stage and still loads product 0.

## Timing
- Edge numbering: start accepted at edge E0.
  - `mac_en` is high in the cycles after E1..E33.
  - `mac_init_bias` is high after E1 only.
  - `act_zero` is high after E33.
  - `logits` are captured at E35.
- Latency E0→`done` high: 35 cycles without argmax, 44 with. Back-to-back start is accepted the cycle after `done`.
- Reset values: every output 0, state IDLE, `logits`=0, `class_idx`=0.
- Reset asserted mid-run: immediate return to IDLE, no `done`. The array is reset through its own active-high synchronous `rst` (driven by `~rst_n` at top); the next inference re-initialises via `init_bias`.
- Memory read latency is fixed at 1 cycle. `rd_addr` never exceeds N_IN-1.

## Configuration
- `L2_SEQ_ARGMAX_EN` defined: ARGMAX state and comparator compiled in; `class_idx` valid when `done`=1.
- Not defined: SETTLE goes directly to DONE; `class_idx` is tied to 0; latency is 35 cycles.

## Structure
- Package `l2_ctrl_pkg`: state enum; constants N_IN=32, N_OUT=10, ACC_W=20, L2_LATENCY=35, L2_ARGMAX_CYCLES=9.
- One sub-module: `argmax_seq`, a sequential signed max-index scanner over a packed vector, instantiated only under the macro.

## Test plan
- All activations=1, weights=1, biases=0 → every logit=32; `class_idx`=0 (tie → lowest); `done` 35/44 cycles after start.
- Lane 7 weights=2, others=1, activations=3, biases=5 → lane 7=197, others=101; `class_idx`=7.
- Activations=-128, weights=127 in lane 0 → lane 0=-520192 (signed, no overflow in 20 bits); all-negative logits select the least-negative lane.
- `abort` at STREAM k=10 → `mac_clr` pulse, no `done`, `busy`=0; a fresh start gives correct logits.
- `rst_n` low mid-DRAIN → all outputs 0 immediately. A start ignored while busy, and two back-to-back inferences, both give independent correct results.
- Addressing: `rd_addr` sequence is 0..31 exactly once per run; `act_zero` is high only in the drain cycle.
